uart_frame: RTL and testbench
=============================

# uart_frame

Parametrised full-duplex UART with configurable data width, parity and stop bits. It replaces the fixed 8N1 UART with valid/ready handshakes on both byte-side interfaces, a receive hold register and receive error flags. It sits between the serial pins and a byte-stream consumer/producer in the same clock domain.

## Interface
Parameters:
- CLK_FREQ, 1000000: system clock frequency in Hz.
- BAUD_RATE, 62500: baud rate; BAUD_CNT = CLK_FREQ/BAUD_RATE; a value below 8 is illegal.
- DATA_BITS, 8: data bits per frame, legal range 5..8.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: transmitted stop bits, 1 or 2.

Ports:
- iCLK  in  1  system clock; the only clock.
- iRST_N  in  1  asynchronous, active-low reset.
- iRX  in  1  serial receive line; asynchronous to iCLK.
- oTX  out  1  serial transmit line.
- iTVALID  in  1  transmit request.
- oTREADY  out  1  transmitter can accept a word.
- iTDATA  in  DATA_BITS  word to transmit.
- oRVALID  out  1  hold register contains an unread word.
- iRREADY  in  1  consumer accepts the held word.
- oRDATA  out  DATA_BITS  received word.
- oPERR  out  1  parity error for the held word; 0 when PARITY = 0.
- oFERR  out  1  framing error for the held word: the first stop bit sampled low.
- oOVR  out  1  sticky overrun flag.

## Operation
- Reset values: oTX=1, oTREADY=1, oRVALID=0, oRDATA=0, oPERR=0, oFERR=0, oOVR=0.
- Reset is asynchronous. Asserting it mid-frame abandons the frame immediately; oTX returns to 1 without waiting for a clock.
- Frame format: start bit (0), then DATA_BITS LSB first, then the parity bit if enabled, then the stop bit(s) (1).
- Parity: even parity bit = XOR of the data bits; odd parity bit = its inverse.
- iRX passes through a 2-flop synchroniser with reset value 1.
- RX states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the synchronised line is low; the bit counter loads 1.
  - In every state, the line is sampled at counts BAUD_CNT/4, BAUD_CNT/2 and 3*BAUD_CNT/4, and the majority of the three samples is the bit value.
  - START: if the majority is 1, the start was false; return to IDLE at count BAUD_CNT and deliver nothing.
  - DATA advances after DATA_BITS bits, then goes to PARITY if PARITY != 0, otherwise to STOP.
  - RX checks only one stop bit, regardless of STOP_BITS.
- Frame completion: at the end of the stop bit (count == BAUD_CNT), load oRDATA, oPERR and oFERR, and set oRVALID. Go to START if the line is already low, otherwise to IDLE.
- A frame with a framing error is still delivered, with oFERR=1.
- RX handshake: the word is consumed on a cycle with oRVALID & iRREADY; oRVALID clears on the next cycle unless a new word loads on the same edge.
- Overrun: a frame that completes while oRVALID=1 and no handshake occurs is dropped. The held word is kept, and oOVR is set.
- oOVR clears on the next handshake.
- A frame completion on the same cycle as a handshake loads the new word; oRVALID stays 1 and oOVR is not set.
- TX states: IDLE, START, DATA, PARITY, STOP.
  - An iTVALID & oTREADY handshake captures iTDATA into the shift register, and oTREADY drops on the next cycle.
  - oTX is registered. The start bit appears on the cycle after the handshake.
  - Each bit lasts exactly BAUD_CNT cycles.
  - During the last cycle of the final stop bit, oTREADY=1. A handshake in that cycle starts the next start bit with no idle gap; otherwise TX returns to IDLE.
- iTVALID may drop without a handshake; TX does not latch the request.

## Timing
- TX frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * BAUD_CNT cycles, measured from the first start-bit cycle of oTX.
- RX latency: oRVALID rises 2 cycles of synchroniser delay plus (frame bits with one stop bit) * BAUD_CNT cycles, plus 1, after the falling edge of iRX.
- Glitch rejection: a low pulse shorter than BAUD_CNT/4 cycles yields no frame.
- Bit counters wrap from BAUD_CNT to 1. They are wide enough for BAUD_CNT up to 65535.

## Structure
- Shared package uart_pkg holds:
  - the parity encodings PAR_NONE, PAR_EVEN, PAR_ODD;
  - the RX/TX state encodings;
  - a frame-length function.
- Sub-module uart_bit_timer is instantiated once for RX and once for TX.
  - Inputs: clear/start.
  - Outputs: the counter value, a tick at BAUD_CNT, and the three sample strobes.

## Test plan
All scenarios use CLK_FREQ=1000000 and BAUD_RATE=62500, so BAUD_CNT=16.
- TX, 8 data bits, even parity, 1 stop (8E1), iTDATA=0xA5 -> oTX is 0,1,0,1,0,0,1,0,1,0,1, 16 cycles each. That is 176 cycles, with oTREADY=0 throughout except the last cycle.
- TX 8N1, words 0x55 and 0xAA presented back to back -> no idle cycle between the first stop bit and the second start bit.
- TX-to-RX loopback, 8N1, 0x3C -> oRDATA=0x3C, oPERR=0, oFERR=0, oRVALID=1 until iRREADY.
- RX with PARITY=2, data 0x01 with parity bit 1 -> oRDATA=0x01, oPERR=1.
- RX with iRX low for 3 cycles -> oRVALID stays 0. RX of 0x7E with the stop bit driven low -> oRDATA=0x7E, oFERR=1.
- RX of 0x11 then 0x22 with iRREADY=0 -> oRDATA=0x11, oOVR=1; after one handshake, oOVR=0 and oRVALID=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_frame block: parity encodings, FSM states
// and small helpers used by both the RTL and the bench.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Total bit periods in one transmitted frame.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs 1..BAUD_CNT and wraps, with a tick on the last
// count and three sample strobes at the quarter points of the bit.
module uart_bit_timer #(
  parameter int BAUD_CNT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        start,
  output logic [15:0] count,
  output logic        tick,
  output logic        smp_a,
  output logic        smp_b,
  output logic        smp_c
);

  localparam logic [15:0] LAST = 16'(BAUD_CNT);
  localparam logic [15:0] Q1   = 16'(BAUD_CNT / 4);
  localparam logic [15:0] Q2   = 16'(BAUD_CNT / 2);
  localparam logic [15:0] Q3   = 16'((3 * BAUD_CNT) / 4);

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      count <= '0;
    else if (clear)                  count <= '0;
    else if (start || count == LAST) count <= 16'd1;
    else if (count != '0)            count <= count + 16'd1;
  end

  assign tick  = (count == LAST);
  assign smp_a = (count == Q1);
  assign smp_b = (count == Q2);
  assign smp_c = (count == Q3);

endmodule

// File: rtl/uart_frame.sv
// Full-duplex UART with configurable width, parity and stop bits, valid/ready
// byte interfaces, an RX hold register and RX error flags.
module uart_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 62500,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iRX,
  output logic                 oTX,
  input  logic                 iTVALID,
  output logic                 oTREADY,
  input  logic [DATA_BITS-1:0] iTDATA,
  output logic                 oRVALID,
  input  logic                 iRREADY,
  output logic [DATA_BITS-1:0] oRDATA,
  output logic                 oPERR,
  output logic                 oFERR,
  output logic                 oOVR
);

  localparam int         BAUD_CNT  = CLK_FREQ / BAUD_RATE;
  localparam bit         PAR_EN    = (PARITY != PAR_NONE);
  localparam bit         PAR_INV   = (PARITY == PAR_ODD);
  localparam bit         TWO_STOP  = (STOP_BITS == 2);
  localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);

  // ---------------- receiver ----------------
  logic [1:0]           rx_sync;
  logic                 line;
  uart_state_e          rx_state, rx_state_n;
  logic                 rx_start, rx_clear, rx_done, rx_hs;
  logic                 rx_tick, rx_sa, rx_sb, rx_sc;
  logic [15:0]          rx_count_unused;
  logic [1:0]           rx_smp;
  logic                 rx_bit, rx_par;
  logic [2:0]           rx_idx;
  logic [DATA_BITS-1:0] rx_shift;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) rx_sync <= 2'b11;
    else         rx_sync <= {rx_sync[0], iRX};
  end
  assign line = rx_sync[1];

  uart_bit_timer #(.BAUD_CNT(BAUD_CNT)) u_rx_timer (
    .clk(iCLK), .rst_n(iRST_N), .clear(rx_clear), .start(rx_start),
    .count(rx_count_unused), .tick(rx_tick), .smp_a(rx_sa), .smp_b(rx_sb), .smp_c(rx_sc)
  );

  // NOTE: defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    rx_state_n = rx_state;
    rx_start   = 1'b0;
    rx_done    = 1'b0;
    case (rx_state)
      ST_IDLE:   if (!line) begin rx_start = 1'b1; rx_state_n = ST_START; end
      ST_START:  if (rx_tick) rx_state_n = rx_bit ? ST_IDLE : ST_DATA;
      ST_DATA:   if (rx_tick && rx_idx == LAST_IDX) rx_state_n = PAR_EN ? ST_PARITY : ST_STOP;
      ST_PARITY: if (rx_tick) rx_state_n = ST_STOP;
      ST_STOP:   if (rx_tick) begin rx_done = 1'b1; rx_state_n = line ? ST_IDLE : ST_START; end
      default:   rx_state_n = ST_IDLE;
    endcase
  end

  assign rx_clear = (rx_state == ST_IDLE) && !rx_start;
  assign rx_hs    = oRVALID && iRREADY;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rx_state <= ST_IDLE;
      rx_smp   <= 2'b11;
      rx_bit   <= 1'b1;
      rx_par   <= 1'b0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      if (rx_sa) rx_smp[0] <= line;
      if (rx_sb) rx_smp[1] <= line;
      if (rx_sc) rx_bit    <= maj3(rx_smp[0], rx_smp[1], line);
      if (rx_state == ST_START) rx_idx <= '0;
      else if (rx_state == ST_DATA && rx_tick) begin
        rx_idx   <= rx_idx + 3'd1;
        rx_shift <= {rx_bit, rx_shift[DATA_BITS-1:1]};
      end
      if (rx_state == ST_PARITY && rx_tick) rx_par <= rx_bit;
    end
  end

  // A completing frame lands in the hold register only if it is free or being
  // emptied this cycle; otherwise it is dropped and the overrun flag sticks.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      // NOTE: the hold register is reset because oRDATA has a defined reset value.
      oRVALID <= 1'b0;
      oRDATA  <= '0;
      oPERR   <= 1'b0;
      oFERR   <= 1'b0;
      oOVR    <= 1'b0;
    end else begin
      if (rx_done && (!oRVALID || rx_hs)) begin
        oRVALID <= 1'b1;
        oRDATA  <= rx_shift;
        oPERR   <= PAR_EN && (rx_par ^ (^rx_shift) ^ PAR_INV);
        oFERR   <= ~rx_bit;
      end else if (rx_hs) begin
        oRVALID <= 1'b0;
      end
      if (rx_done && oRVALID && !rx_hs) oOVR <= 1'b1;
      else if (rx_hs)                   oOVR <= 1'b0;
    end
  end

  // ---------------- transmitter ----------------
  uart_state_e          tx_state, tx_state_n;
  logic                 tx_hs, tx_clear, tx_tick, tx_last_stop, tx_n;
  logic [15:0]          tx_count_unused;
  logic [2:0]           tx_smp_unused;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par, tx_stop;
  logic [2:0]           tx_idx;

  uart_bit_timer #(.BAUD_CNT(BAUD_CNT)) u_tx_timer (
    .clk(iCLK), .rst_n(iRST_N), .clear(tx_clear), .start(tx_hs),
    .count(tx_count_unused), .tick(tx_tick),
    .smp_a(tx_smp_unused[0]), .smp_b(tx_smp_unused[1]), .smp_c(tx_smp_unused[2])
  );

  assign tx_last_stop = (tx_state == ST_STOP) && tx_tick && (tx_stop == TWO_STOP);
  assign oTREADY      = (tx_state == ST_IDLE) || tx_last_stop;
  assign tx_hs        = iTVALID && oTREADY;
  assign tx_clear     = (tx_state == ST_IDLE) && !tx_hs;

  // tx_n is the line value for the bit that starts on the coming edge.
  always_comb begin
    tx_state_n = tx_state;
    tx_n       = oTX;
    case (tx_state)
      ST_IDLE: if (tx_hs) begin tx_state_n = ST_START; tx_n = 1'b0; end
      ST_START: if (tx_tick) begin tx_state_n = ST_DATA; tx_n = tx_shift[0]; end
      ST_DATA: if (tx_tick) begin
        if (tx_idx == LAST_IDX) begin
          tx_state_n = PAR_EN ? ST_PARITY : ST_STOP;
          tx_n       = PAR_EN ? tx_par : 1'b1;
        end else begin
          tx_n = tx_shift[1];
        end
      end
      ST_PARITY: if (tx_tick) begin tx_state_n = ST_STOP; tx_n = 1'b1; end
      ST_STOP: if (tx_last_stop) begin
        tx_state_n = tx_hs ? ST_START : ST_IDLE;
        tx_n       = ~tx_hs;
      end
      default: begin tx_state_n = ST_IDLE; tx_n = 1'b1; end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      tx_state <= ST_IDLE;
      oTX      <= 1'b1;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_stop  <= 1'b0;
      tx_idx   <= '0;
    end else begin
      tx_state <= tx_state_n;
      oTX      <= tx_n;
      if (tx_hs) begin
        tx_shift <= iTDATA;
        tx_par   <= (^iTDATA) ^ PAR_INV;
      end else if (tx_state == ST_DATA && tx_tick) begin
        tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
      end
      if (tx_state == ST_START)                 tx_idx <= '0;
      else if (tx_state == ST_DATA && tx_tick)  tx_idx <= tx_idx + 3'd1;
      if (tx_state != ST_STOP)                  tx_stop <= 1'b0;
      else if (tx_tick)                         tx_stop <= ~tx_stop;
    end
  end

endmodule

// File: tb/tb_uart_frame.sv
// Directed bench for uart_frame: three instances (8E1 TX, 8N1 TX/RX/loopback,
// 8O1 RX) driven from one sequence of scenario tasks.
module tb_uart_frame;
  import uart_pkg::*;

  localparam int BC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  // 8E1 instance, transmit only
  logic       e_tx, e_tready, e_tvalid = 1'b0, e_rvalid, e_rready = 1'b0;
  logic       e_perr, e_ferr, e_ovr, e_rx = 1'b1;
  logic [7:0] e_tdata = '0, e_rdata;

  uart_frame #(.CLK_FREQ(1000000), .BAUD_RATE(62500), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_e (
    .iCLK(clk), .iRST_N(rst_n), .iRX(e_rx), .oTX(e_tx), .iTVALID(e_tvalid), .oTREADY(e_tready),
    .iTDATA(e_tdata), .oRVALID(e_rvalid), .iRREADY(e_rready), .oRDATA(e_rdata),
    .oPERR(e_perr), .oFERR(e_ferr), .oOVR(e_ovr)
  );

  // 8N1 instance, RX either driven by the bench or looped back from its TX
  logic       n_tx, n_tready, n_tvalid = 1'b0, n_rvalid, n_rready = 1'b0;
  logic       n_perr, n_ferr, n_ovr, n_rx, n_rx_drv = 1'b1, loop = 1'b0;
  logic [7:0] n_tdata = '0, n_rdata;
  assign n_rx = loop ? n_tx : n_rx_drv;

  uart_frame #(.CLK_FREQ(1000000), .BAUD_RATE(62500), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u_n (
    .iCLK(clk), .iRST_N(rst_n), .iRX(n_rx), .oTX(n_tx), .iTVALID(n_tvalid), .oTREADY(n_tready),
    .iTDATA(n_tdata), .oRVALID(n_rvalid), .iRREADY(n_rready), .oRDATA(n_rdata),
    .oPERR(n_perr), .oFERR(n_ferr), .oOVR(n_ovr)
  );

  // 8O1 instance, receive only
  logic       o_tx, o_tready, o_tvalid = 1'b0, o_rvalid, o_rready = 1'b0;
  logic       o_perr, o_ferr, o_ovr, o_rx = 1'b1;
  logic [7:0] o_tdata = '0, o_rdata;

  uart_frame #(.CLK_FREQ(1000000), .BAUD_RATE(62500), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1)) u_o (
    .iCLK(clk), .iRST_N(rst_n), .iRX(o_rx), .oTX(o_tx), .iTVALID(o_tvalid), .oTREADY(o_tready),
    .iTDATA(o_tdata), .oRVALID(o_rvalid), .iRREADY(o_rready), .oRDATA(o_rdata),
    .oPERR(o_perr), .oFERR(o_ferr), .oOVR(o_ovr)
  );

  task automatic drive_n(input logic [11:0] bits, input int nb);
    for (int b = 0; b < nb; b++) begin
      n_rx_drv = bits[b];
      repeat (BC) @(negedge clk);
    end
    n_rx_drv = 1'b1;
  endtask

  task automatic drive_o(input logic [11:0] bits, input int nb);
    for (int b = 0; b < nb; b++) begin
      o_rx = bits[b];
      repeat (BC) @(negedge clk);
    end
    o_rx = 1'b1;
  endtask

  task automatic wait_n_rvalid(input int budget, input string name);
    int k = 0;
    while (!n_rvalid && k < budget) begin @(negedge clk); k++; end
    n_total++;
    if (n_rvalid !== 1'b1) $display("FAIL %s timeout: rvalid=%b want 1", name, n_rvalid);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++; if (e_tx !== 1'b1)     $display("FAIL rst_tx got %b want 1", e_tx);         else n_pass++;
    n_total++; if (e_tready !== 1'b1) $display("FAIL rst_tready got %b want 1", e_tready); else n_pass++;
    n_total++; if (n_rvalid !== 1'b0) $display("FAIL rst_rvalid got %b want 0", n_rvalid); else n_pass++;
    n_total++; if (n_rdata !== 8'h00) $display("FAIL rst_rdata got %h want 00", n_rdata);  else n_pass++;
    n_total++; if (n_perr !== 1'b0)   $display("FAIL rst_perr got %b want 0", n_perr);     else n_pass++;
    n_total++; if (n_ferr !== 1'b0)   $display("FAIL rst_ferr got %b want 0", n_ferr);     else n_pass++;
    n_total++; if (n_ovr !== 1'b0)    $display("FAIL rst_ovr got %b want 0", n_ovr);       else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // 0xA5, even parity 0: start 0, data 1,0,1,0,0,1,0,1, parity 0, stop 1
  task automatic test_tx_8e1();
    logic [10:0] fe;
    int len;
    fe  = {1'b1, 1'b0, 8'hA5, 1'b0};
    len = frame_bits(8, PAR_EVEN, 1) * BC;
    @(negedge clk);
    e_tvalid = 1'b1; e_tdata = 8'hA5;
    n_total++; if (e_tready !== 1'b1) $display("FAIL e1_ready_idle got %b want 1", e_tready); else n_pass++;
    @(negedge clk);
    e_tvalid = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      n_total++;
      if (e_tx !== fe[i/BC]) $display("FAIL e1_tx cycle %0d got %b want %b", i, e_tx, fe[i/BC]);
      else n_pass++;
      n_total++;
      if (e_tready !== (i == len - 1)) $display("FAIL e1_tready cycle %0d got %b want %b", i, e_tready, (i == len - 1));
      else n_pass++;
    end
    @(negedge clk);
    n_total++; if (e_tx !== 1'b1)     $display("FAIL e1_tx_idle got %b want 1", e_tx);         else n_pass++;
    n_total++; if (e_tready !== 1'b1) $display("FAIL e1_tready_idle got %b want 1", e_tready); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [19:0] fb;
    fb = {1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0};
    @(negedge clk);
    n_tvalid = 1'b1; n_tdata = 8'h55;
    n_total++; if (n_tready !== 1'b1) $display("FAIL b2b_ready got %b want 1", n_tready); else n_pass++;
    @(negedge clk);
    n_tdata = 8'hAA;
    for (int i = 0; i < 20 * BC; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 10 * BC) n_tvalid = 1'b0;
      n_total++;
      if (n_tx !== fb[i/BC]) $display("FAIL b2b_tx cycle %0d got %b want %b", i, n_tx, fb[i/BC]);
      else n_pass++;
      n_total++;
      if (n_tready !== (i == 10 * BC - 1 || i == 20 * BC - 1))
        $display("FAIL b2b_tready cycle %0d got %b want %b", i, n_tready, (i == 10 * BC - 1 || i == 20 * BC - 1));
      else n_pass++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loopback();
    loop = 1'b1;
    @(negedge clk);
    n_tvalid = 1'b1; n_tdata = 8'h3C;
    @(negedge clk);
    n_tvalid = 1'b0;
    wait_n_rvalid(400, "lb_rvalid");
    n_total++; if (n_rdata !== 8'h3C) $display("FAIL lb_rdata got %h want 3c", n_rdata); else n_pass++;
    n_total++; if (n_perr !== 1'b0)   $display("FAIL lb_perr got %b want 0", n_perr);    else n_pass++;
    n_total++; if (n_ferr !== 1'b0)   $display("FAIL lb_ferr got %b want 0", n_ferr);    else n_pass++;
    repeat (10) @(negedge clk);
    n_total++; if (n_rvalid !== 1'b1) $display("FAIL lb_hold got %b want 1", n_rvalid);  else n_pass++;
    n_rready = 1'b1;
    @(negedge clk);
    n_rready = 1'b0;
    n_total++; if (n_rvalid !== 1'b0) $display("FAIL lb_consume got %b want 0", n_rvalid); else n_pass++;
    loop = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_glitch();
    n_rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    n_rx_drv = 1'b1;
    repeat (60) @(negedge clk);
    n_total++; if (n_rvalid !== 1'b0) $display("FAIL glitch_rvalid got %b want 0", n_rvalid); else n_pass++;
  endtask

  task automatic test_framing();
    drive_n(12'({1'b0, 8'h7E, 1'b0}), 10);
    wait_n_rvalid(40, "ferr_rvalid");
    n_total++; if (n_rdata !== 8'h7E) $display("FAIL ferr_rdata got %h want 7e", n_rdata); else n_pass++;
    n_total++; if (n_ferr !== 1'b1)   $display("FAIL ferr_flag got %b want 1", n_ferr);    else n_pass++;
    n_total++; if (n_perr !== 1'b0)   $display("FAIL ferr_perr got %b want 0", n_perr);    else n_pass++;
    n_rready = 1'b1;
    @(negedge clk);
    n_rready = 1'b0;
    repeat (40) @(negedge clk);
    n_total++; if (n_rvalid !== 1'b0) $display("FAIL ferr_after got %b want 0", n_rvalid); else n_pass++;
  endtask

  task automatic test_overrun();
    drive_n(12'({1'b1, 8'h11, 1'b0}), 10);
    drive_n(12'({1'b1, 8'h22, 1'b0}), 10);
    repeat (10) @(negedge clk);
    n_total++; if (n_rvalid !== 1'b1) $display("FAIL ovr_rvalid got %b want 1", n_rvalid); else n_pass++;
    n_total++; if (n_rdata !== 8'h11) $display("FAIL ovr_rdata got %h want 11", n_rdata);  else n_pass++;
    n_total++; if (n_ovr !== 1'b1)    $display("FAIL ovr_flag got %b want 1", n_ovr);      else n_pass++;
    n_rready = 1'b1;
    @(negedge clk);
    n_rready = 1'b0;
    n_total++; if (n_ovr !== 1'b0)    $display("FAIL ovr_clear got %b want 0", n_ovr);       else n_pass++;
    n_total++; if (n_rvalid !== 1'b0) $display("FAIL ovr_rvalid_clr got %b want 0", n_rvalid); else n_pass++;
  endtask

  // 0x01 has odd data parity, so the correct odd-parity bit is 0; send 1
  task automatic test_parity_odd();
    int k = 0;
    drive_o(12'({1'b1, 1'b1, 8'h01, 1'b0}), 11);
    while (!o_rvalid && k < 40) begin @(negedge clk); k++; end
    n_total++; if (o_rvalid !== 1'b1) $display("FAIL par_rvalid timeout got %b want 1", o_rvalid); else n_pass++;
    n_total++; if (o_rdata !== 8'h01) $display("FAIL par_rdata got %h want 01", o_rdata); else n_pass++;
    n_total++; if (o_perr !== 1'b1)   $display("FAIL par_perr got %b want 1", o_perr);    else n_pass++;
    n_total++; if (o_ferr !== 1'b0)   $display("FAIL par_ferr got %b want 0", o_ferr);    else n_pass++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    e_tvalid = 1'b1; e_tdata = 8'hFF;
    @(negedge clk);
    e_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (e_tx !== 1'b0) $display("FAIL ar_start got %b want 0", e_tx); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (e_tx !== 1'b1)     $display("FAIL ar_tx got %b want 1", e_tx);         else n_pass++;
    n_total++; if (e_tready !== 1'b1) $display("FAIL ar_tready got %b want 1", e_tready); else n_pass++;
    n_total++; if (o_rvalid !== 1'b0) $display("FAIL ar_rvalid got %b want 0", o_rvalid); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_tx_8e1();
    test_back_to_back();
    test_loopback();
    test_glitch();
    test_framing();
    test_overrun();
    test_parity_odd();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench still running, want finished");
    $fatal(1);
  end

endmodule
